// File: rtl/pci_pkg.sv
// Shared definitions for the PCI arbiter: state codes, master count,
// grant timeout and the active-low one-hot helper.
package pci_pkg;

    localparam int unsigned N_MASTERS       = 8;
    localparam int unsigned PCI_GNT_TIMEOUT = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PARK  = 3'd1;
    localparam logic [2:0] ST_GRANT = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_YIELD = 3'd4;

    function automatic logic [N_MASTERS-1:0] onehot_n(input logic [2:0] idx);
        logic [N_MASTERS-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin picker: first active-low request found scanning
// upward from last+1 with wrap; last itself is considered last.
module pci_rr_pick
    import pci_pkg::*;
(
    input  logic [N_MASTERS-1:0] req_n,
    input  logic [2:0]           last,
    output logic [2:0]           winner,
    output logic                 any_req
);

    always_comb begin
        logic [2:0] idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            idx = last + k[2:0];
            if (!any_req && !req_n[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grants with parking, unused-grant
// timeout and hidden arbitration; registered active-low one-hot grant.
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int unsigned N_MASTERS   = 8,
    parameter bit          PARK_EN     = 1'b1,
    parameter int unsigned PARK_ID     = 0,
    parameter int unsigned GNT_TIMEOUT = PCI_GNT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req_n,
    input  logic                 frame_n,
    input  logic                 irdy_n,
    output logic [N_MASTERS-1:0] gnt_n,
    output logic                 gnt_vld
);

    localparam int unsigned TW = $clog2(GNT_TIMEOUT);
    localparam logic [2:0]    PARK_IDX = 3'(PARK_ID);
    localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TIMEOUT - 1);

    logic [2:0]           state_q, state_d;
    logic [2:0]           cur_q, cur_d;
    logic [2:0]           last_q, last_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [N_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic                 gnt_vld_q, gnt_vld_d;

    logic [2:0] winner;
    logic       any_req;
    logic       bus_idle;
    logic       others_req;

    pci_rr_pick u_pick (
        .req_n   (req_n),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign bus_idle   = frame_n & irdy_n;
    assign others_req = |(~req_n & onehot_n(cur_q));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    cur_d   = winner;
                    timer_d = '0;
                end else if (PARK_EN) begin
                    state_d = ST_PARK;
                    cur_d   = PARK_IDX;
                end
            end
            ST_PARK: begin
                if (!frame_n) begin
                    state_d = ST_BUSY;
                    cur_d   = PARK_IDX;
                    last_d  = PARK_IDX;
                end else if (any_req && winner == PARK_IDX) begin
                    state_d = ST_GRANT;
                    cur_d   = PARK_IDX;
                    timer_d = '0;
                end else if (any_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // FRAME# wins over withdrawal and timeout in the same cycle
                if (!frame_n) begin
                    state_d = ST_BUSY;
                    last_d  = cur_q;
                end else if (req_n[cur_q]) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    last_d  = cur_q;
                end else if (bus_idle) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_BUSY: begin
                if (others_req) begin
                    state_d = ST_YIELD;
                end else if (bus_idle && !req_n[cur_q]) begin
                    state_d = ST_GRANT;
                    timer_d = '0;
                end else if (bus_idle) begin
                    state_d = ST_IDLE;
                end
            end
            ST_YIELD: begin
                if (bus_idle) begin
                    if (any_req) begin
                        state_d = ST_GRANT;
                        cur_d   = winner;
                        timer_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        gnt_n_d   = '1;
        gnt_vld_d = 1'b0;
        if (state_d == ST_PARK || state_d == ST_GRANT || state_d == ST_BUSY) begin
            gnt_n_d   = onehot_n(cur_d);
            gnt_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            last_q    <= 3'd7;
            timer_q   <= '0;
            gnt_n_q   <= '1;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            gnt_n_q   <= gnt_n_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign gnt_n   = gnt_n_q;
    assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Bench for pci_arbiter: two instances (parking on 0 and on 3) driven with
// shared stimulus and checked against an owner/flag based reference model.
module tb_pci_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_n = 8'hFF;
    logic       frame_n = 1'b1;
    logic       irdy_n = 1'b1;
    logic [7:0] gnt0, gnt3;
    logic       vld0, vld3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pci_arbiter dut0 (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .frame_n(frame_n),
        .irdy_n(irdy_n), .gnt_n(gnt0), .gnt_vld(vld0)
    );

    pci_arbiter #(.PARK_EN(1'b1), .PARK_ID(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .frame_n(frame_n),
        .irdy_n(irdy_n), .gnt_n(gnt3), .gnt_vld(vld3)
    );

    // Model: owner = granted master or -1; flags say why the grant is held.
    typedef struct {
        int owner;
        bit parked;
        bit busy;
        bit yield;
        int tmr;
        int last;
    } mdl_t;

    mdl_t m0, m3;
    logic [7:0] prev0 = 8'hFF, prev3 = 8'hFF;

    function automatic int pick(logic [7:0] req, int last);
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (last + k) % 8;
            if (!req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic mdl_t model_next(mdl_t m, int park, logic r, logic [7:0] q,
                                        logic f, logic i);
        mdl_t n;
        int   w;
        bit   idle;
        n    = m;
        idle = f & i;
        w    = pick(q, m.last);
        if (!r) begin
            n = '{owner: -1, parked: 0, busy: 0, yield: 0, tmr: 0, last: 7};
        end else if (m.yield) begin
            if (idle) begin
                n.yield = 0;
                if (w >= 0) begin n.owner = w; n.tmr = 0; end
            end
        end else if (m.owner < 0) begin
            if (w >= 0) begin n.owner = w; n.tmr = 0; end
            else begin n.owner = park; n.parked = 1; end
        end else if (m.parked) begin
            if (!f) begin n.parked = 0; n.busy = 1; n.last = park; end
            else if (w == park) begin n.parked = 0; n.tmr = 0; end
            else if (w >= 0) begin n.parked = 0; n.owner = -1; end
        end else if (m.busy) begin
            if ((~q & ~(8'h01 << m.owner)) != 8'h00) begin
                n.busy = 0; n.yield = 1; n.owner = -1;
            end else if (idle && !q[m.owner]) begin
                n.busy = 0; n.tmr = 0;
            end else if (idle) begin
                n.busy = 0; n.owner = -1;
            end
        end else begin
            if (!f) begin n.busy = 1; n.last = m.owner; end
            else if (q[m.owner]) n.owner = -1;
            else if (m.tmr == 15) begin n.last = m.owner; n.owner = -1; end
            else if (idle) n.tmr = m.tmr + 1;
        end
        return n;
    endfunction

    function automatic logic [7:0] mgnt(mdl_t m);
        logic [7:0] v;
        v = 8'hFF;
        if (m.owner >= 0) v = ~(8'h01 << m.owner);
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_shape(input string name, input logic [7:0] g, input logic [7:0] p);
        logic ok;
        ok = (g == 8'hFF) || $onehot(~g);
        chk({name, "_onehot"}, {7'b0, ok}, 8'h01);
        if (p != 8'hFF && g != 8'hFF) chk({name, "_nogap_move"}, g, p);
    endtask

    task automatic step(input logic r, input logic [7:0] q, input logic f, input logic i);
        rst_n = r; req_n = q; frame_n = f; irdy_n = i;
        @(posedge clk);
        m0 = model_next(m0, 0, r, q, f, i);
        m3 = model_next(m3, 3, r, q, f, i);
        #1;
        chk("model_gnt0", gnt0, mgnt(m0));
        chk("model_vld0", {7'b0, vld0}, {7'b0, m0.owner >= 0});
        chk("model_gnt3", gnt3, mgnt(m3));
        chk("model_vld3", {7'b0, vld3}, {7'b0, m3.owner >= 0});
        check_shape("dut0", gnt0, prev0);
        check_shape("dut3", gnt3, prev3);
        prev0 = gnt0;
        prev3 = gnt3;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       f;
        logic       i;
        logic [7:0] e0;
        logic [7:0] e3;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int         order[4];
        logic [7:0] e;
        logic [7:0] rq;
        int         gaps;
        int         waited;

        m0 = '{owner: -1, parked: 0, busy: 0, yield: 0, tmr: 0, last: 7};
        m3 = m0;

        // reset, parking on 0 vs 3, park handover, gap to a foreign winner
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF};
        tbl[2]  = '{1'b1, 8'h00, 1'b1, 1'b1, 8'hFE, 8'hFE};
        tbl[3]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF};
        tbl[4]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFE, 8'hF7};
        tbl[5]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFE, 8'hF7};
        tbl[6]  = '{1'b1, 8'hF7, 1'b1, 1'b1, 8'hFF, 8'hF7};
        tbl[7]  = '{1'b1, 8'hF7, 1'b1, 1'b1, 8'hF7, 8'hF7};
        tbl[8]  = '{1'b1, 8'hDF, 1'b1, 1'b1, 8'hFF, 8'hFF};
        tbl[9]  = '{1'b1, 8'hDF, 1'b1, 1'b1, 8'hDF, 8'hDF};
        tbl[10] = '{1'b1, 8'hDF, 1'b0, 1'b1, 8'hDF, 8'hDF};
        tbl[11] = '{1'b1, 8'hDF, 1'b0, 1'b1, 8'hDF, 8'hDF};
        tbl[12] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'hFF};
        tbl[13] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFE, 8'hF7};

        for (int k = 0; k < 14; k++) begin
            step(tbl[k].rst, tbl[k].req, tbl[k].f, tbl[k].i);
            chk($sformatf("tbl%0d_gnt0", k), gnt0, tbl[k].e0);
            chk($sformatf("tbl%0d_gnt3", k), gnt3, tbl[k].e3);
        end
        chk("reset_vld_after_park", {7'b0, vld3}, 8'h01);

        // hidden arbitration: master 1 busy, master 6 requests
        step(1'b1, 8'hFD, 1'b1, 1'b1);  chk("hid_gap", gnt0, 8'hFF);
        step(1'b1, 8'hFD, 1'b1, 1'b1);  chk("hid_gnt1", gnt0, 8'hFD);
        step(1'b1, 8'hFD, 1'b0, 1'b1);  chk("hid_busy1", gnt0, 8'hFD);
        step(1'b1, 8'hBD, 1'b0, 1'b1);  chk("hid_yield", gnt0, 8'hFF);
        step(1'b1, 8'hBD, 1'b0, 1'b1);  chk("hid_yield_hold", gnt0, 8'hFF);
        step(1'b1, 8'hBD, 1'b1, 1'b1);  chk("hid_gnt6", gnt0, 8'hBF);

        // unused-grant timeout for master 1
        step(1'b1, 8'hFF, 1'b1, 1'b1);  chk("tmo_pre_idle", gnt0, 8'hFF);
        step(1'b1, 8'hFF, 1'b1, 1'b1);  chk("tmo_pre_park", gnt0, 8'hFE);
        step(1'b1, 8'hFD, 1'b1, 1'b1);  chk("tmo_gap", gnt0, 8'hFF);
        step(1'b1, 8'hFD, 1'b1, 1'b1);  chk("tmo_gnt_first", gnt0, 8'hFD);
        for (int k = 1; k < 16; k++) begin
            step(1'b1, 8'hFD, 1'b1, 1'b1);
            chk($sformatf("tmo_hold%0d", k), gnt0, 8'hFD);
        end
        step(1'b1, 8'hFD, 1'b1, 1'b1);  chk("tmo_revoke", gnt0, 8'hFF);
        step(1'b1, 8'hFD, 1'b1, 1'b1);  chk("tmo_regrant", gnt0, 8'hFD);

        // reset in the middle of master 2's transaction
        step(1'b1, 8'hFB, 1'b1, 1'b1);  chk("rst_gap", gnt0, 8'hFF);
        step(1'b1, 8'hFB, 1'b1, 1'b1);  chk("rst_gnt2", gnt0, 8'hFB);
        step(1'b1, 8'hFB, 1'b0, 1'b1);  chk("rst_busy2", gnt0, 8'hFB);
        step(1'b0, 8'hFB, 1'b0, 1'b1);  chk("rst_abort", gnt0, 8'hFF);
        chk("rst_abort_vld", {7'b0, vld0}, 8'h00);
        step(1'b1, 8'hEA, 1'b1, 1'b1);  chk("rst_restart0", gnt0, 8'hFE);

        // round robin among 0, 2, 4 with three-clock transactions
        order[0] = 0; order[1] = 2; order[2] = 4; order[3] = 0;
        gaps = 0;
        for (int n = 0; n < 4; n++) begin
            e = ~(8'h01 << order[n]);
            waited = 0;
            while (gnt0 != e && waited < 8) begin
                if (gnt0 == 8'hFF) gaps++;
                step(1'b1, 8'hEA, 1'b1, 1'b1);
                waited++;
            end
            chk($sformatf("rr_owner%0d", n), gnt0, e);
            if (n > 0) chk($sformatf("rr_gap%0d", n), {7'b0, gaps > 0}, 8'h01);
            gaps = 0;
            for (int c = 0; c < 3; c++) begin
                step(1'b1, 8'hEA, 1'b0, 1'b1);
                if (gnt0 == 8'hFF) gaps++;
            end
        end

        // randomized traffic against the model
        rq = 8'hFF;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) rq = ~(8'($urandom) & 8'($urandom));
            step(($urandom_range(0, 79) != 0), rq,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
